flash_read: RTL
===============

Name: flash_read

Overview:
- Single-clock read-cycle generator for the parallel NOR flash bus.
- Converts a one-cycle `rd_en` request into an asynchronous flash read cycle, samples the bus, and returns the word with a `rd_done` pulse.
- Counterpart of the flash write-cycle block. Both sit under the flash controller, which muxes their bus outputs onto the shared pins.

Parameters:
- T_ACC, 6, number of clocks from the `oe_n` falling edge to the data-sample edge, plus one; legal range 2..15.
- T_REC, 2, number of clocks `ce_n` is held high after a read before a new request is accepted; legal range 1..15.
- T_PAGE, 3, number of clocks per subsequent word in page mode; only used with `FLASH_PAGE_RD_EN`; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- rd_en  in  1  one-cycle read request; honoured only when `rd_busy`=0.
- rd_addr  in  25  word address; captured on the accepted `rd_en`.
- rd_data  out  16  read word; held until the next sample.
- rd_valid  out  1  one-cycle pulse, high on the cycle each word is captured into `rd_data`.
- rd_done  out  1  one-cycle pulse, high on the cycle the last word of a request is captured.
- rd_busy  out  1  high from the accepted request until return to IDLE.
- dq_oe  out  1  data-bus drive enable; constant 0 (this block never drives `dq`).
- dq_i  in  16  flash data bus input.
- a  out  25  flash address.
- ce_n  out  1  chip enable.
- oe_n  out  1  output enable.
- we_n  out  1  write enable; constant 1.
- adv_n  out  1  address valid.

Behaviour:
- All outputs are registered except the constants `dq_oe`, `we_n`.
- Reset values: `a`=0, `rd_data`=0, `ce_n`=1, `oe_n`=1, `adv_n`=1, `rd_valid`=0, `rd_done`=0, `rd_busy`=0, state=IDLE, counter=0.
- Asserting reset mid-cycle aborts immediately to the reset values. No `rd_done` is produced for the aborted request.
- States: IDLE, SETUP, ACCESS, RECOVER.
- Timeline, with edge E0 being the edge that samples `rd_en`=1 in IDLE:
  - E0: latch `rd_addr`, `rd_busy`<=1, go to SETUP.
  - E1 (SETUP): `a`<=latched address, `ce_n`<=0, `adv_n`<=0, counter<=0, go to ACCESS.
  - E2: `adv_n`<=1, `oe_n`<=0. Counter increments on every ACCESS edge.
  - Edge E(1+T_ACC): `rd_data`<=`dq_i`, `rd_valid`<=1, `rd_done`<=1, `ce_n`<=1, `oe_n`<=1, `a`<=0, go to RECOVER. `oe_n` is therefore low for T_ACC-1 clock periods before the sample.
  - RECOVER: `rd_valid`/`rd_done` return to 0 on the next edge. After T_REC edges in RECOVER, `rd_busy`<=0 and state goes to IDLE.
- Default request latency: `rd_en` edge to `rd_done` high = T_ACC+1 clocks (7 at default).
- Minimum spacing between accepted requests = T_ACC+T_REC+2 clocks.
- `rd_en` while `rd_busy`=1 (including the `rd_done` cycle) is ignored and not queued; `rd_addr` is not re-latched.
- `rd_en` on the first IDLE cycle after RECOVER is accepted.
- `adv_n` is low for exactly one clock per request.

Optional Feature:
- Macro: `FLASH_PAGE_RD_EN`.
- Defined:
  - Adds input `rd_len` [2:0] (words-1), latched with `rd_addr`.
  - After the first word is sampled, `ce_n`/`oe_n` stay low, `a[2:0]` increments modulo 8 and `a[24:3]` is unchanged (wrap within the 8-word page).
  - Each further word is sampled T_PAGE clocks after the address change, with one `rd_valid` pulse per word.
  - `rd_done`, deassertion of `ce_n`/`oe_n`, and `a`<=0 occur only on the last word, then RECOVER.
  - `rd_len`=0 behaves exactly as the non-page build.
- Undefined: no `rd_len` port; `rd_valid` equals `rd_done`.

Test Plan:
- Reset, then idle 10 clocks -> `ce_n`=`oe_n`=`adv_n`=`we_n`=1, `a`=0, `rd_data`=0, `dq_oe`=0, `rd_busy`=0.
- `rd_en` with `rd_addr`=0x1ABCDE, flash model returns 0x5A3C after T_ACC-1 oe-low clocks -> `a`=0x1ABCDE from E1, `adv_n` low only E1–E2, `rd_done` at E7, `rd_data`=0x5A3C, `rd_busy` low at E9.
- `rd_en` pulsed at E3 and on the `rd_done` cycle of an active read -> ignored, single `rd_done`, address unchanged. A pulse on the first IDLE cycle is accepted.
- Back-to-back reads to 0x000000 and 0x1FFFFFF with data 0x0000/0xFFFF -> correct words, `ce_n` high ≥ T_REC clocks between cycles.
- `rst_n` asserted at E4 -> outputs at reset values asynchronously, no `rd_done`, next request completes normally.
- (`FLASH_PAGE_RD_EN`) `rd_addr`=0x000006, `rd_len`=3 -> addresses 6,7,0,1 with upper bits 0, four `rd_valid` pulses spaced T_PAGE, `rd_done` only with the fourth word.

Source files
------------

// File: rtl/flash_read.sv
// flash_read: turns a one-cycle rd_en request into an asynchronous NOR flash read cycle.
// Define FLASH_PAGE_RD_EN to add page-mode bursts of up to 8 words selected by rd_len.
module flash_read #(
  parameter int unsigned T_ACC  = 6,
  parameter int unsigned T_REC  = 2,
  parameter int unsigned T_PAGE = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic [24:0] rd_addr,
`ifdef FLASH_PAGE_RD_EN
  input  logic [2:0]  rd_len,
`endif
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        rd_done,
  output logic        rd_busy,
  output logic        dq_oe,
  input  logic [15:0] dq_i,
  output logic [24:0] a,
  output logic        ce_n,
  output logic        oe_n,
  output logic        we_n,
  output logic        adv_n
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RECOVER} state_e;

  localparam logic [3:0] ACC_LAST  = 4'(T_ACC - 1);
  localparam logic [3:0] PAGE_LAST = 4'(T_PAGE - 1);
  localparam logic [3:0] REC_LAST  = 4'(T_REC - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [24:0] addr_q, addr_d;
  logic [2:0]  len_q, len_d;
  logic        first_q, first_d;
  logic [24:0] a_q, a_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        adv_n_q, adv_n_d;
  logic        rd_valid_q, rd_valid_d;
  logic        rd_done_q, rd_done_d;
  logic        rd_busy_q, rd_busy_d;

  logic [2:0]  len_in;
  logic        sample_hit;
  logic        last_word;

  // Without page mode every request is a single word, so the burst logic folds away.
`ifdef FLASH_PAGE_RD_EN
  assign len_in = rd_len;
`else
  assign len_in = 3'd0;
`endif

  // The first word waits the full access time; later page words only T_PAGE.
  assign sample_hit = (cnt_q == (first_q ? ACC_LAST : PAGE_LAST));
  assign last_word  = (len_q == 3'd0);

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: each combinational block assigns defaults first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rd_en) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (sample_hit && last_word) state_d = RECOVER;
      RECOVER: if (cnt_q == REC_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    len_d      = len_q;
    first_d    = first_q;
    a_d        = a_q;
    rd_data_d  = rd_data_q;
    ce_n_d     = ce_n_q;
    oe_n_d     = oe_n_q;
    adv_n_d    = adv_n_q;
    rd_valid_d = 1'b0;
    rd_done_d  = 1'b0;
    rd_busy_d  = rd_busy_q;
    unique case (state_q)
      IDLE: begin
        if (rd_en) begin
          addr_d    = rd_addr;
          len_d     = len_in;
          rd_busy_d = 1'b1;
        end
      end
      SETUP: begin
        a_d     = addr_q;
        ce_n_d  = 1'b0;
        adv_n_d = 1'b0;
        cnt_d   = 4'd0;
        first_d = 1'b1;
      end
      ACCESS: begin
        adv_n_d = 1'b1;
        oe_n_d  = 1'b0;
        if (sample_hit) begin
          rd_data_d  = dq_i;
          rd_valid_d = 1'b1;
          cnt_d      = 4'd0;
          first_d    = 1'b0;
          if (last_word) begin
            rd_done_d = 1'b1;
            ce_n_d    = 1'b1;
            oe_n_d    = 1'b1;
            a_d       = '0;
          end else begin
            // Page wrap: only the low three address bits advance.
            a_d   = {a_q[24:3], a_q[2:0] + 3'd1};
            len_d = len_q - 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RECOVER: begin
        if (cnt_q == REC_LAST) begin
          rd_busy_d = 1'b0;
          cnt_d     = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      len_q      <= 3'd0;
      first_q    <= 1'b0;
      a_q        <= '0;
      rd_data_q  <= '0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      adv_n_q    <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_done_q  <= 1'b0;
      rd_busy_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      first_q    <= first_d;
      a_q        <= a_d;
      rd_data_q  <= rd_data_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      adv_n_q    <= adv_n_d;
      rd_valid_q <= rd_valid_d;
      rd_done_q  <= rd_done_d;
      rd_busy_q  <= rd_busy_d;
    end
  end

  assign a        = a_q;
  assign rd_data  = rd_data_q;
  assign ce_n     = ce_n_q;
  assign oe_n     = oe_n_q;
  assign adv_n    = adv_n_q;
  assign rd_valid = rd_valid_q;
  assign rd_done  = rd_done_q;
  assign rd_busy  = rd_busy_q;
  assign dq_oe    = 1'b0;
  assign we_n     = 1'b1;

endmodule
